// File: rtl/wb_host_loader_if.sv
// Host command/response byte channels and Wishbone classic initiator signals
// shared between wb_host_loader, the host link and the backdoor responder.
interface wb_host_loader_if;
  logic [7:0]  cmd_data;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  rsp_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] wb_addr_o;
  logic [31:0] wb_data_o;
  logic        wb_we_o;
  logic        wb_cyc_o;
  logic        wb_strobe_o;
  logic [31:0] wb_data_i;
  logic        wb_ack_i;

  modport master (
    input  cmd_data, cmd_valid, rsp_ready, wb_data_i, wb_ack_i,
    output cmd_ready, rsp_data, rsp_valid,
           wb_addr_o, wb_data_o, wb_we_o, wb_cyc_o, wb_strobe_o
  );

  modport slave (
    output cmd_data, cmd_valid, rsp_ready, wb_data_i, wb_ack_i,
    input  cmd_ready, rsp_data, rsp_valid,
           wb_addr_o, wb_data_o, wb_we_o, wb_cyc_o, wb_strobe_o
  );
endinterface

// File: rtl/wb_host_loader.sv
// Byte-stream command decoder that turns each host command into one
// single-beat Wishbone classic cycle and streams the result back.
module wb_host_loader #(
  parameter int TIMEOUT = 255
) (
  input  logic              clock,
  input  logic              reset_n,
  wb_host_loader_if.master  bus,
  output logic              busy
);

  typedef enum logic [2:0] {IDLE, ADDR, DATA, BUS, RESP} state_t;

  localparam logic [7:0]  OP_WRITE    = 8'h57;
  localparam logic [7:0]  OP_READ     = 8'h52;
  localparam logic [7:0]  RSP_ACK     = 8'h4B;
  localparam logic [7:0]  RSP_TIMEOUT = 8'h45;
  localparam logic [7:0]  RSP_BAD_OP  = 8'h3F;
  localparam logic [15:0] TIMER_LAST  = 16'(TIMEOUT - 1);

  state_t      state, state_d;
  logic        is_write, is_write_d;
  logic [1:0]  byte_cnt, byte_cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [31:0] rsp_buf, rsp_buf_d;
  logic [1:0]  rsp_left, rsp_left_d;
  logic [15:0] timer, timer_d;
  logic        cmd_fire;
  logic        rsp_fire;

  // Bus strobes come straight from the state register so that an
  // asynchronous reset drops them without waiting for a clock edge.
  assign bus.cmd_ready   = (state == IDLE) || (state == ADDR) || (state == DATA);
  assign bus.rsp_valid   = (state == RESP);
  assign bus.rsp_data    = rsp_buf[31:24];
  assign bus.wb_cyc_o    = (state == BUS);
  assign bus.wb_strobe_o = (state == BUS);
  assign bus.wb_we_o     = (state == BUS) && is_write;
  assign bus.wb_addr_o   = addr_q;
  assign bus.wb_data_o   = data_q;
  assign busy            = (state != IDLE);

  assign cmd_fire = bus.cmd_valid && bus.cmd_ready;
  assign rsp_fire = bus.rsp_valid && bus.rsp_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      is_write <= 1'b0;
      byte_cnt <= 2'd0;
      addr_q   <= 32'h0;
      data_q   <= 32'h0;
      rsp_buf  <= 32'h0;
      rsp_left <= 2'd0;
      timer    <= 16'h0;
    end else begin
      state    <= state_d;
      is_write <= is_write_d;
      byte_cnt <= byte_cnt_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      rsp_buf  <= rsp_buf_d;
      rsp_left <= rsp_left_d;
      timer    <= timer_d;
    end
  end

  // Response bytes leave from the top of rsp_buf; rsp_left counts the bytes
  // still to follow the one currently presented.
  always_comb begin
    state_d    = state;
    is_write_d = is_write;
    byte_cnt_d = byte_cnt;
    addr_d     = addr_q;
    data_d     = data_q;
    rsp_buf_d  = rsp_buf;
    rsp_left_d = rsp_left;
    timer_d    = timer;

    case (state)
      IDLE: begin
        if (cmd_fire) begin
          if ((bus.cmd_data == OP_WRITE) || (bus.cmd_data == OP_READ)) begin
            is_write_d = (bus.cmd_data == OP_WRITE);
            byte_cnt_d = 2'd0;
            state_d    = ADDR;
          end else begin
            rsp_buf_d  = {RSP_BAD_OP, 24'h0};
            rsp_left_d = 2'd0;
            state_d    = RESP;
          end
        end
      end

      ADDR: begin
        if (cmd_fire) begin
          addr_d     = {addr_q[23:0], bus.cmd_data};
          byte_cnt_d = byte_cnt + 2'd1;
          if (byte_cnt == 2'd3) begin
            timer_d = 16'h0;
            state_d = is_write ? DATA : BUS;
          end
        end
      end

      DATA: begin
        if (cmd_fire) begin
          data_d     = {data_q[23:0], bus.cmd_data};
          byte_cnt_d = byte_cnt + 2'd1;
          if (byte_cnt == 2'd3) begin
            timer_d = 16'h0;
            state_d = BUS;
          end
        end
      end

      // An acknowledge on the same edge as the final timer count takes priority.
      BUS: begin
        if (bus.wb_ack_i) begin
          if (is_write) begin
            rsp_buf_d  = {RSP_ACK, 24'h0};
            rsp_left_d = 2'd0;
          end else begin
            rsp_buf_d  = bus.wb_data_i;
            rsp_left_d = 2'd3;
          end
          state_d = RESP;
        end else if (timer == TIMER_LAST) begin
          rsp_buf_d  = {RSP_TIMEOUT, 24'h0};
          rsp_left_d = 2'd0;
          state_d    = RESP;
        end else begin
          timer_d = timer + 16'd1;
        end
      end

      RESP: begin
        if (rsp_fire) begin
          rsp_buf_d = {rsp_buf[23:0], 8'h0};
          if (rsp_left == 2'd0) begin
            state_d = IDLE;
          end else begin
            rsp_left_d = rsp_left - 2'd1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_wb_host_loader.sv
// Self-checking bench for wb_host_loader: directed vector table, hand-written
// corner sequences and a randomized run against a memory-level reference model.
module tb_wb_host_loader;

  localparam int TIMEOUT = 8;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic busy;

  wb_host_loader_if bus ();

  wb_host_loader #(.TIMEOUT(TIMEOUT)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus),
    .busy    (busy)
  );

  always #5 clock = ~clock;

  int compared = 0;
  int mismatched = 0;

  // Responder controls and observations
  int          ack_delay = 0;
  bit          stray_ack = 1'b0;
  bit          use_mem = 1'b0;
  logic [31:0] fixed_rd = 32'h0;
  logic [31:0] mem [logic [31:0]];
  int          cyc_cnt = 0;
  int          last_cyc_cycles = 0;
  int          txn_count = 0;
  int          stab_err = 0;
  logic [31:0] last_addr = 32'h0;
  logic [31:0] last_data = 32'h0;
  logic        last_we = 1'b0;

  int gap_max = 0;
  int rsp_gap_max = 0;

  typedef struct {
    string       name;
    logic [7:0]  op;
    logic [31:0] addr;
    logic [31:0] data;
    int          ack_delay;
    logic [31:0] rd_val;
    int          n_rsp;
    logic [31:0] rsp_bytes;
    int          cyc_cycles;
    logic        we;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Wishbone responder: acks on the ack_delay-th cycle of cyc (0 = never)
  // and watches the request for stability across the whole cycle.
  initial begin
    forever begin
      @(negedge clock);
      if (bus.wb_cyc_o) begin
        cyc_cnt++;
        if (cyc_cnt == 1) begin
          txn_count++;
          last_addr = bus.wb_addr_o;
          last_data = bus.wb_data_o;
          last_we   = bus.wb_we_o;
        end else if (bus.wb_addr_o !== last_addr || bus.wb_data_o !== last_data ||
                     bus.wb_we_o !== last_we) begin
          stab_err++;
        end
        if (!bus.wb_strobe_o) stab_err++;
        last_cyc_cycles = cyc_cnt;
        if (ack_delay != 0 && cyc_cnt == ack_delay) begin
          bus.wb_ack_i = 1'b1;
          if (bus.wb_we_o) begin
            if (use_mem) mem[bus.wb_addr_o] = bus.wb_data_o;
            bus.wb_data_i = $urandom;
          end else if (use_mem) begin
            bus.wb_data_i = mem.exists(bus.wb_addr_o) ? mem[bus.wb_addr_o] : 32'h0;
          end else begin
            bus.wb_data_i = fixed_rd;
          end
        end else begin
          bus.wb_ack_i  = 1'b0;
          bus.wb_data_i = $urandom;
        end
      end else begin
        cyc_cnt       = 0;
        bus.wb_ack_i  = stray_ack;
        bus.wb_data_i = 32'hBAD0BAD0;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n;
    logic rdy;
    if (gap_max > 0) repeat ($urandom_range(0, gap_max)) @(negedge clock);
    bus.cmd_data  = b;
    bus.cmd_valid = 1'b1;
    n = 0;
    do begin
      rdy = bus.cmd_ready;
      @(negedge clock);
      n++;
    end while (!rdy && n < 100);
    bus.cmd_valid = 1'b0;
    if (!rdy) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL cmd_handshake: cmd_ready stayed 0, required 1 within 100 cycles");
    end
  endtask

  task automatic recv_byte(output logic [7:0] b);
    int n;
    if (rsp_gap_max > 0) repeat ($urandom_range(0, rsp_gap_max)) @(negedge clock);
    bus.rsp_ready = 1'b1;
    n = 0;
    while (!bus.rsp_valid && n < 100) begin
      @(negedge clock);
      n++;
    end
    b = bus.rsp_data;
    if (!bus.rsp_valid) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL rsp_handshake: rsp_valid stayed 0, required 1 within 100 cycles");
    end
    @(negedge clock);
    bus.rsp_ready = 1'b0;
  endtask

  task automatic send_cmd(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] data);
    send_byte(op);
    if (op == 8'h57 || op == 8'h52) begin
      for (int i = 3; i >= 0; i--) send_byte(addr[8*i +: 8]);
      if (op == 8'h57) begin
        for (int i = 3; i >= 0; i--) send_byte(data[8*i +: 8]);
      end
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    int txn0;
    int stab0;
    logic [7:0] b;
    use_mem   = 1'b0;
    fixed_rd  = v.rd_val;
    ack_delay = v.ack_delay;
    txn0      = txn_count;
    stab0     = stab_err;
    send_cmd(v.op, v.addr, v.data);
    if (v.cyc_cycles > 0) begin
      check({v.name, "_cyc_after_last_byte"}, {31'h0, bus.wb_cyc_o}, 32'h1);
      check({v.name, "_stb_after_last_byte"}, {31'h0, bus.wb_strobe_o}, 32'h1);
    end
    for (int k = 0; k < v.n_rsp; k++) begin
      recv_byte(b);
      check($sformatf("%s_rsp%0d", v.name, k), {24'h0, b}, {24'h0, v.rsp_bytes[31-8*k -: 8]});
    end
    checkOutput(v, txn0, stab0);
  endtask

  task automatic checkOutput(input vec_t v, input int txn0, input int stab0);
    check({v.name, "_rsp_valid_done"}, {31'h0, bus.rsp_valid}, 32'h0);
    check({v.name, "_busy_done"}, {31'h0, busy}, 32'h0);
    check({v.name, "_cmd_ready_done"}, {31'h0, bus.cmd_ready}, 32'h1);
    check({v.name, "_bus_cycles"}, 32'(txn_count - txn0), (v.cyc_cycles > 0) ? 32'h1 : 32'h0);
    check({v.name, "_stable"}, 32'(stab_err - stab0), 32'h0);
    if (v.cyc_cycles > 0) begin
      check({v.name, "_cyc_len"}, 32'(last_cyc_cycles), 32'(v.cyc_cycles));
      check({v.name, "_addr"}, last_addr, v.addr);
      check({v.name, "_we"}, {31'h0, last_we}, {31'h0, v.we});
      if (v.we) check({v.name, "_wdata"}, last_data, v.data);
    end
  endtask

  vec_t vecs [9];
  logic [31:0] ref_mem [logic [31:0]];

  initial begin
    logic [7:0] b;
    logic [7:0] op;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] rd;
    int dly;
    int n_exp;
    logic [31:0] exp_bytes;

    vecs[0] = '{"write",      8'h57, 32'h00000004, 32'hDEADBEEF, 3, 32'h0,        1, 32'h4B000000, 3, 1'b1};
    vecs[1] = '{"read",       8'h52, 32'h00010010, 32'h0,        1, 32'h0000000A, 4, 32'h0000000A, 1, 1'b0};
    vecs[2] = '{"timeout_wr", 8'h57, 32'h00000020, 32'h11223344, 0, 32'h0,        1, 32'h45000000, 8, 1'b1};
    vecs[3] = '{"ack_last",   8'h52, 32'h00000030, 32'h0,        8, 32'hCAFEF00D, 4, 32'hCAFEF00D, 8, 1'b0};
    vecs[4] = '{"bad_op",     8'h41, 32'h0,        32'h0,        1, 32'h0,        1, 32'h3F000000, 0, 1'b0};
    vecs[5] = '{"rd_after_bad", 8'h52, 32'h00000000, 32'h0,      2, 32'h00000055, 4, 32'h00000055, 2, 1'b0};
    vecs[6] = '{"write_ack1", 8'h57, 32'hFFFFFFFC, 32'h0F0F0F0F, 1, 32'h0,        1, 32'h4B000000, 1, 1'b1};
    vecs[7] = '{"timeout_rd", 8'h52, 32'h00000044, 32'h0,        9, 32'h12345678, 1, 32'h45000000, 8, 1'b0};
    vecs[8] = '{"ack_7",      8'h57, 32'h00000050, 32'hA5A5A5A5, 7, 32'h0,        1, 32'h4B000000, 7, 1'b1};

    bus.cmd_data  = 8'h0;
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b0;

    repeat (3) @(negedge clock);
    check("reset_cyc", {31'h0, bus.wb_cyc_o}, 32'h0);
    check("reset_stb", {31'h0, bus.wb_strobe_o}, 32'h0);
    check("reset_we", {31'h0, bus.wb_we_o}, 32'h0);
    check("reset_rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
    check("reset_busy", {31'h0, busy}, 32'h0);
    check("reset_addr", bus.wb_addr_o, 32'h0);
    check("reset_data", bus.wb_data_o, 32'h0);
    check("reset_rsp_data", {24'h0, bus.rsp_data}, 32'h0);
    check("reset_cmd_ready", {31'h0, bus.cmd_ready}, 32'h1);
    reset_n = 1'b1;
    @(negedge clock);

    for (int i = 0; i < 9; i++) applyStimulus(vecs[i]);

    // Stray acknowledge while idle must not start anything
    begin
      int txn0;
      txn0 = txn_count;
      stray_ack = 1'b1;
      for (int i = 0; i < 3; i++) begin
        @(negedge clock);
        check("stray_ack_cyc", {31'h0, bus.wb_cyc_o}, 32'h0);
        check("stray_ack_busy", {31'h0, busy}, 32'h0);
      end
      stray_ack = 1'b0;
      @(negedge clock);
      check("stray_ack_txn", 32'(txn_count - txn0), 32'h0);
    end

    // Backpressure: gapped command bytes, host stalls 5 cycles mid-response
    gap_max   = 2;
    use_mem   = 1'b0;
    fixed_rd  = 32'h89ABCDEF;
    ack_delay = 2;
    send_cmd(8'h52, 32'h00000100, 32'h0);
    recv_byte(b);
    check("stall_rsp0", {24'h0, b}, 32'h89);
    recv_byte(b);
    check("stall_rsp1", {24'h0, b}, 32'hAB);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("stall_valid", {31'h0, bus.rsp_valid}, 32'h1);
      check("stall_data", {24'h0, bus.rsp_data}, 32'hCD);
    end
    recv_byte(b);
    check("stall_rsp2", {24'h0, b}, 32'hCD);
    recv_byte(b);
    check("stall_rsp3", {24'h0, b}, 32'hEF);
    check("stall_done_valid", {31'h0, bus.rsp_valid}, 32'h0);
    check("stall_done_busy", {31'h0, busy}, 32'h0);
    gap_max = 0;

    // Reset asserted while the bus cycle is outstanding
    ack_delay = 0;
    send_cmd(8'h57, 32'h00000008, 32'h01020304);
    repeat (3) @(negedge clock);
    check("midreset_bus_up", {31'h0, bus.wb_cyc_o}, 32'h1);
    reset_n = 1'b0;
    #1;
    check("midreset_cyc", {31'h0, bus.wb_cyc_o}, 32'h0);
    check("midreset_stb", {31'h0, bus.wb_strobe_o}, 32'h0);
    check("midreset_rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
    check("midreset_busy", {31'h0, busy}, 32'h0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    applyStimulus('{"post_reset_wr", 8'h57, 32'h00000040, 32'h13579BDF, 2, 32'h0, 1, 32'h4B000000, 2, 1'b1});

    // Randomized traffic against a memory-level model of the loader
    use_mem     = 1'b1;
    gap_max     = 2;
    rsp_gap_max = 3;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 9))
        0:          op = (($urandom_range(0, 1) == 0) ? 8'h00 : 8'hA7);
        1, 2, 3, 4: op = 8'h57;
        default:    op = 8'h52;
      endcase
      addr = 32'h1000 + 32'($urandom_range(0, 3) * 4);
      data = $urandom;
      dly  = int'($urandom_range(0, 10));
      ack_delay = dly;

      if (op != 8'h57 && op != 8'h52) begin
        n_exp = 1; exp_bytes = 32'h3F000000;
      end else if (dly >= 1 && dly <= TIMEOUT) begin
        if (op == 8'h57) begin
          ref_mem[addr] = data;
          n_exp = 1; exp_bytes = 32'h4B000000;
        end else begin
          rd = ref_mem.exists(addr) ? ref_mem[addr] : 32'h0;
          n_exp = 4; exp_bytes = rd;
        end
      end else begin
        n_exp = 1; exp_bytes = 32'h45000000;
      end

      send_cmd(op, addr, data);
      for (int k = 0; k < n_exp; k++) begin
        recv_byte(b);
        check($sformatf("rand%0d_op%0h_rsp%0d", i, op, k), {24'h0, b}, {24'h0, exp_bytes[31-8*k -: 8]});
      end
      check($sformatf("rand%0d_rsp_valid_done", i), {31'h0, bus.rsp_valid}, 32'h0);
    end
    check("rand_stable", 32'(stab_err), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation still running, required completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched + 1);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
